// File: rtl/acc_fpu_arbiter.sv
// rtl/acc_fpu_arbiter.sv - round-robin sharing of one FPU between NUM_REQ requesters
// Requester id rides in the FPU tag so out-of-order results route back; credits bound in-flight ops.
module acc_fpu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int PAYLOAD_W  = 128,
    parameter int RESULT_W   = 37,
    parameter int USER_TAG_W = 4,
    parameter int MAX_OUT    = 4,
    parameter int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TAG_W      = ID_W + USER_TAG_W,
    parameter int CNT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload_i,
    input  logic [NUM_REQ*USER_TAG_W-1:0] req_tag_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [RESULT_W-1:0]           resp_data_o,
    output logic [USER_TAG_W-1:0]         resp_tag_o,
    output logic                          fpu_in_valid_o,
    input  logic                          fpu_in_ready_i,
    output logic [PAYLOAD_W-1:0]          fpu_payload_o,
    output logic [TAG_W-1:0]              fpu_tag_o,
    input  logic                          fpu_out_valid_i,
    output logic                          fpu_out_ready_o,
    input  logic [RESULT_W-1:0]           fpu_result_i,
    input  logic [TAG_W-1:0]              fpu_tag_i,
    input  logic                          fpu_busy_i,
    output logic                          fpu_flush_o,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic [CNT_W-1:0]              outstanding_o
);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t          state, state_n;
    logic            slot_valid;
    logic [ID_W-1:0] last_grant, grant_id, cand, rsp_id;
    logic            grant_en, grant_any, rsp_hs, drain_done;

    assign fpu_in_valid_o = slot_valid;
    assign resp_data_o    = fpu_result_i;
    assign resp_tag_o     = fpu_tag_i[USER_TAG_W-1:0];
    assign rsp_id         = fpu_tag_i[TAG_W-1 -: ID_W];
    assign drain_done     = !fpu_busy_i && !fpu_out_valid_i;
    // Credit check uses the registered count: a same-cycle response does not free a credit early.
    assign grant_en       = (state == RUN) && !flush_i && (!slot_valid || fpu_in_ready_i)
                            && (outstanding_o < CNT_W'(MAX_OUT));
    assign rsp_hs         = (state == RUN) && fpu_out_valid_i && fpu_out_ready_o;
    assign busy_o         = (state != RUN) || slot_valid || (outstanding_o != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RUN:     if (flush_i) state_n = FLUSH;
            FLUSH:   state_n = DRAIN;
            DRAIN:   if (drain_done) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        req_ready_o     = '0;
        resp_valid_o    = '0;
        fpu_out_ready_o = 1'b0;
        fpu_flush_o     = (state == FLUSH);
        grant_any       = 1'b0;
        grant_id        = '0;
        cand            = '0;
        if (grant_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
                if (!grant_any && req_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
        if (grant_any) req_ready_o[grant_id] = 1'b1;
        if (state == RUN) begin
            // Ids with no matching requester are accepted and dropped so the FPU never wedges.
            if (int'(rsp_id) < NUM_REQ) begin
                resp_valid_o[rsp_id] = fpu_out_valid_i;
                fpu_out_ready_o      = fpu_out_valid_i && resp_ready_i[rsp_id];
            end else begin
                fpu_out_ready_o = fpu_out_valid_i;
            end
        end else if (state == DRAIN) begin
            fpu_out_ready_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid    <= 1'b0;
            fpu_payload_o <= '0;
            fpu_tag_o     <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            outstanding_o <= '0;
        end else begin
            if (state == RUN && flush_i) begin
                slot_valid <= 1'b0;
            end else if (grant_any) begin
                slot_valid    <= 1'b1;
                fpu_payload_o <= req_payload_i[grant_id*PAYLOAD_W +: PAYLOAD_W];
                fpu_tag_o     <= {grant_id, req_tag_i[grant_id*USER_TAG_W +: USER_TAG_W]};
                last_grant    <= grant_id;
            end else if (fpu_in_ready_i) begin
                slot_valid <= 1'b0;
            end

            if (state == DRAIN && drain_done) begin
                outstanding_o <= '0;
            end else if (grant_any && !rsp_hs) begin
                outstanding_o <= outstanding_o + CNT_W'(1);
            end else if (!grant_any && rsp_hs) begin
                outstanding_o <= outstanding_o - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_fpu_arbiter.sv
// tb/tb_acc_fpu_arbiter.sv - scoreboard bench for acc_fpu_arbiter
module tb_acc_fpu_arbiter;
    localparam int NR = 2, PW = 128, RW = 37, UW = 4, MO = 4, TW = 5, CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, resp_valid, resp_ready;
    logic [NR*PW-1:0]  req_payload;
    logic [NR*UW-1:0]  req_tag;
    logic [RW-1:0]     resp_data, fpu_result;
    logic [UW-1:0]     resp_tag;
    logic              fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready;
    logic [PW-1:0]     fpu_payload;
    logic [TW-1:0]     fpu_tag_out, fpu_tag_in;
    logic              fpu_busy, fpu_flush, flush, busy;
    logic [CW-1:0]     outstanding;

    always #5 clk = ~clk;

    acc_fpu_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .RESULT_W(RW), .USER_TAG_W(UW), .MAX_OUT(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_payload_i(req_payload), .req_tag_i(req_tag),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_tag_o(resp_tag),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_payload_o(fpu_payload), .fpu_tag_o(fpu_tag_out),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_result_i(fpu_result), .fpu_tag_i(fpu_tag_in),
        .fpu_busy_i(fpu_busy), .fpu_flush_o(fpu_flush),
        .flush_i(flush), .busy_o(busy), .outstanding_o(outstanding)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [PW-1:0] pay;
    } issue_t;

    issue_t exp_q[$];
    int     grants[$];
    int     checks = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester handshakes push the expected FPU issue; FPU input handshakes pop and compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (fpu_in_valid && fpu_in_ready) begin
                if (exp_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    issue_t e;
                    e = exp_q.pop_front();
                    check("issue_tag", fpu_tag_out, e.tag);
                    check("issue_payload", fpu_payload, e.pay);
                end
            end
            if (req_ready != '0) begin
                check("ready_implies_valid", req_ready & ~req_valid, 0);
                check("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i] && req_valid[i]) begin
                        exp_q.push_back('{tag: {1'(i), req_tag[i*UW +: UW]}, pay: req_payload[i*PW +: PW]});
                        grants.push_back(i);
                    end
                end
            end
        end
    end

    task automatic respond(input logic [TW-1:0] tag, input logic [RW-1:0] data,
                           input logic [NR-1:0] exp_valid, input string name);
        fpu_out_valid = 1'b1;
        fpu_tag_in    = tag;
        fpu_result    = data;
        #1;
        check({name, "_resp_valid"}, resp_valid, exp_valid);
        check({name, "_resp_tag"}, resp_tag, tag[UW-1:0]);
        check({name, "_resp_data"}, resp_data, data);
        check({name, "_out_ready"}, fpu_out_ready, resp_ready[tag[TW-1]]);
        step();
        fpu_out_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = '0; req_payload = '0; req_tag = '0;
        fpu_in_ready = 1'b0; fpu_out_valid = 1'b0; fpu_result = '0; fpu_tag_in = '0;
        fpu_busy = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_valid", fpu_in_valid, 0);
        check("rst_payload", fpu_payload, 0);
        check("rst_tag", fpu_tag_out, 0);
        check("rst_flush", fpu_flush, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_out_ready", fpu_out_ready, 0);
        rst = 1'b0;
        step();

        // single op
        fpu_in_ready = 1'b1; resp_ready = 2'b11;
        req_payload[0 +: PW] = 128'h0123_4567_89ab_cdef_0000_aaaa_5555_ffff;
        req_payload[PW +: PW] = 128'hfeed_0000_beef_1111;
        req_tag[0 +: UW] = 4'h5; req_valid = 2'b01;
        #1 check("single_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        check("single_in_valid", fpu_in_valid, 1);
        check("single_tag", fpu_tag_out, 5'h05);
        check("single_outstanding1", outstanding, 1);
        step();
        check("single_slot_empty", fpu_in_valid, 0);
        respond(5'h05, 37'h1_2345_6789, 2'b01, "single");
        check("single_outstanding0", outstanding, 0);
        check("single_idle", busy, 0);

        // fairness and credit limit: last grant was 0, so 1 goes first
        grants.delete();
        req_tag[0 +: UW] = 4'h1; req_tag[UW +: UW] = 4'h2; req_valid = 2'b11;
        repeat (6) step();
        check("credit_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) check("fair_order", grants[i], (i % 2 == 0) ? 1 : 0);
        check("credit_ready_low", req_ready, 0);
        check("credit_outstanding", outstanding, 4);
        respond(5'h12, 37'h0_0000_0a0a, 2'b10, "credit");
        check("credit_regrant", req_ready, 2'b10);
        step();
        req_valid = '0;
        check("credit_outstanding_refill", outstanding, 4);

        // out of order with back-pressure on id 1
        resp_ready = 2'b01;
        fpu_out_valid = 1'b1; fpu_tag_in = 5'h12; fpu_result = 37'h0_dead;
        #1;
        check("ooo_hold_valid", resp_valid, 2'b10);
        check("ooo_hold_ready", fpu_out_ready, 0);
        step();
        check("ooo_hold_count", outstanding, 4);
        resp_ready = 2'b11;
        respond(5'h12, 37'h0_dead, 2'b10, "ooo_id1");
        respond(5'h01, 37'h1_beef, 2'b01, "ooo_id0");
        respond(5'h12, 37'h0_0042, 2'b10, "ooo_id1b");
        respond(5'h01, 37'h0_0077, 2'b01, "ooo_id0b");
        check("ooo_outstanding0", outstanding, 0);

        // FPU stall: slot must hold while not accepted
        fpu_in_ready = 1'b0;
        req_tag[0 +: UW] = 4'h7; req_valid = 2'b01;
        #1 check("stall_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            check("stall_no_grant", req_ready, 0);
            check("stall_tag", fpu_tag_out, 5'h07);
            check("stall_payload", fpu_payload, req_payload[0 +: PW]);
            step();
        end
        fpu_in_ready = 1'b1;
        #1 check("stall_release_grant", req_ready, 2'b10);
        step();
        req_valid = '0;
        step();
        check("stall_outstanding", outstanding, 2);

        // grant and response handshake together leave the count unchanged
        req_valid = 2'b01;
        fpu_out_valid = 1'b1; fpu_tag_in = 5'h07; fpu_result = 37'h0_0101;
        step();
        req_valid = '0; fpu_out_valid = 1'b0;
        check("same_cycle_count", outstanding, 2);
        step();
        req_valid = 2'b10;
        step();
        req_valid = '0;
        step();
        check("flush_pre_count", outstanding, 3);
        check("flush_pre_queue", exp_q.size(), 0);

        // flush with three in flight
        fpu_busy = 1'b1; flush = 1'b1; req_valid = 2'b01;
        #1 check("flush_blocks_grant", req_ready, 0);
        step();
        flush = 1'b0;
        check("flush_pulse", fpu_flush, 1);
        check("flush_busy", busy, 1);
        check("flush_no_grant", req_ready, 0);
        step();
        check("flush_pulse_end", fpu_flush, 0);
        fpu_out_valid = 1'b1; fpu_tag_in = 5'h12; fpu_result = 37'h0_0bad;
        #1;
        check("drain_discard", resp_valid, 0);
        check("drain_out_ready", fpu_out_ready, 1);
        check("drain_no_grant", req_ready, 0);
        step();
        fpu_out_valid = 1'b0; fpu_busy = 1'b0;
        #1 check("drain_exit_no_grant", req_ready, 0);
        step();
        check("flush_outstanding0", outstanding, 0);
        check("flush_resume_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        step();
        check("post_flush_queue", exp_q.size(), 0);

        // asynchronous reset mid-operation
        fpu_in_ready = 1'b0; req_valid = 2'b10;
        step();
        req_valid = '0;
        check("pre_rst_valid", fpu_in_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", fpu_in_valid, 0);
        check("async_rst_count", outstanding, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
